// File: rtl/aes_out_unpacker.sv
// Purpose: tracks blocks through a pipelined AES core, buffers results and serialises them as 32-bit words.
// Latency: first word valid the cycle after edge accept+LATENCY; backpressure: out_ready stalls words, credits throttle in_ready.
// Optional flow control: define AES_OUT_CREDIT_EN to gate in_ready on a credit counter; otherwise in_ready=1 and overflow drops.
module aes_out_unpacker #(
    parameter int LATENCY = 12,
    parameter int DEPTH   = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] aes_data,
    output logic [31:0]  out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_last,
    output logic         overflow
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [LATENCY-1:0] dly_q, dly_d;
    logic [127:0]       mem_q [DEPTH];
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [1:0]         idx_q, idx_d;
    logic               ovf_q, ovf_d;

    logic         accept;
    logic         capture;
    logic         full;
    logic         hs;
    logic         pop;
    logic         push;
    logic [127:0] head;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign accept    = in_valid & in_ready;
    assign capture   = dly_q[LATENCY-1];
    assign full      = (cnt_q == CW'(DEPTH));
    assign out_valid = (cnt_q != '0);
    assign hs        = out_valid & out_ready;
    assign pop       = hs & (idx_q == 2'd3);
    // A capture into a full FIFO still lands if the head leaves on the same edge.
    assign push      = capture & (~full | pop);

    always_comb begin
        dly_d    = (dly_q << 1) | LATENCY'(accept);
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        idx_d    = hs   ? idx_q + 2'd1      : idx_q;
        ovf_d    = ovf_q | (capture & full & ~pop);
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dly_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            idx_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            dly_q    <= dly_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage needs no reset: occupancy gates everything read from it.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= aes_data;
        end
    end

    assign head = mem_q[rd_ptr_q];

    always_comb begin
        out_data = '0;
        if (out_valid) begin
            case (idx_q)
                2'd0:    out_data = head[127:96];
                2'd1:    out_data = head[95:64];
                2'd2:    out_data = head[63:32];
                default: out_data = head[31:0];
            endcase
        end
    end

    assign out_last = out_valid & (idx_q == 2'd3);
    assign overflow = ovf_q;

`ifdef AES_OUT_CREDIT_EN
    // Credits cover blocks in the core pipeline plus blocks resident in the FIFO.
    logic [CW-1:0] credit_q, credit_d;

    always_comb begin
        case ({accept, pop})
            2'b10:   credit_d = credit_q + 1'b1;
            2'b01:   credit_d = credit_q - 1'b1;
            default: credit_d = credit_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credit_q <= '0;
        end else begin
            credit_q <= credit_d;
        end
    end

    assign in_ready = (credit_q < CW'(DEPTH));
`else
    assign in_ready = 1'b1;
`endif

endmodule

// File: tb/tb_aes_out_unpacker.sv
// Randomised and directed scoreboard bench for aes_out_unpacker; the bench plays the AES core.
module tb_aes_out_unpacker;

    localparam int L = 12;
    localparam int D = 4;
`ifdef AES_OUT_CREDIT_EN
    localparam bit CREDIT = 1'b1;
`else
    localparam bit CREDIT = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] aes_data = '0;
    logic [31:0]  out_data;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic         out_last;
    logic         overflow;

    aes_out_unpacker #(.LATENCY(L), .DEPTH(D)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .aes_data (aes_data),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_last (out_last),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int ecnt = 0;
    logic [127:0] hist [64];

    // reference model state
    logic [127:0] mfifo[$];
    int           pend_due[$];
    logic [127:0] pend_dat[$];
    logic [31:0]  exp_w[$];
    bit           exp_l[$];
    int           hd = 0;
    bit           m_ovf = 0;
    int           credit = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic bit m_ready();
        return CREDIT ? (credit < D) : 1'b1;
    endfunction

    function automatic logic [127:0] rblk();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Model: each edge applies the behavioural rules to the queues.
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                mfifo.delete(); pend_due.delete(); pend_dat.delete();
                exp_w.delete(); exp_l.delete();
                hd = 0; m_ovf = 0; credit = 0;
            end else begin
                int n, sz;
                bit hs, pop, acc, cap;
                logic [127:0] d;
                n   = ecnt;
                sz  = mfifo.size();
                hs  = (sz > 0) && out_ready;
                pop = hs && (hd == 3);
                acc = in_valid && m_ready();
                cap = (pend_due.size() > 0) && (pend_due[0] == n);
                if (hs) begin
                    if (pop) begin
                        void'(mfifo.pop_front());
                        hd = 0;
                    end else begin
                        hd++;
                    end
                end
                if (cap) begin
                    d = pend_dat.pop_front();
                    void'(pend_due.pop_front());
                    if (sz < D || pop) begin
                        mfifo.push_back(d);
                        for (int w = 0; w < 4; w++) begin
                            exp_w.push_back(d[127 - 32*w -: 32]);
                            exp_l.push_back(w == 3);
                        end
                    end else begin
                        m_ovf = 1;
                    end
                end
                if (acc) begin
                    pend_due.push_back(n + L);
                    pend_dat.push_back(hist[n % 64]);
                end
                credit = credit + int'(acc) - int'(pop);
            end
        end
    end

    // Monitor: compares DUT outputs mid-cycle and consumes scoreboard words on handshake.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                chk("rst_out_valid", out_valid, 0);
                chk("rst_out_last", out_last, 0);
                chk("rst_out_data", out_data, 0);
                chk("rst_in_ready", in_ready, 1);
                chk("rst_overflow", overflow, 0);
            end else begin
                chk("out_valid", out_valid, mfifo.size() > 0);
                chk("in_ready", in_ready, m_ready());
                chk("overflow", overflow, m_ovf);
                chk("occupancy", dut.cnt_q, mfifo.size());
                if (out_valid && exp_w.size() > 0) begin
                    chk("out_data", out_data, exp_w[0]);
                    chk("out_last", out_last, exp_l[0]);
                    if (out_ready) begin
                        void'(exp_w.pop_front());
                        void'(exp_l.pop_front());
                    end
                end
            end
        end
    end

    // Drive inputs for edge ecnt; aes_data carries the core result for the block presented L edges earlier.
    task automatic cycle(input bit iv, input bit ordy, input logic [127:0] blk);
        in_valid = iv;
        out_ready = ordy;
        hist[ecnt % 64] = blk;
        aes_data = (ecnt >= L) ? hist[(ecnt - L) % 64] : '0;
        @(posedge clk);
        #1;
        ecnt++;
    endtask

    task automatic idle(input int n, input bit ordy);
        for (int i = 0; i < n; i++) cycle(1'b0, ordy, rblk());
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle(2, 1'b0);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [127:0] ct;
        ct = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

        idle(3, 1'b0);
        rst_n = 1'b1;
        idle(2, 1'b0);

        // single known-answer block, first word timing
        cycle(1'b1, 1'b1, ct);
        for (int k = 0; k <= L; k++) begin
            chk("kat_first_word_timing", out_valid, k == L);
            if (k == L) chk("kat_word0", out_data, 32'h69c4e0d8);
            cycle(1'b0, 1'b1, rblk());
        end
        idle(8, 1'b1);

        // three blocks held behind a 20-cycle stall
        for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0, rblk());
        idle(17, 1'b0);
        idle(20, 1'b1);

        // full FIFO with last-word pop coinciding with a capture
        for (int k = 0; k <= L + 8; k++) begin
            cycle((k < 4) || (k == 5), k >= L + 2, rblk());
`ifndef AES_OUT_CREDIT_EN
            if (k == L + 5) begin
                chk("full_same_edge_occ", dut.cnt_q, 4);
                chk("full_same_edge_ovf", overflow, 0);
            end
`endif
        end
        idle(30, 1'b1);

`ifdef AES_OUT_CREDIT_EN
        // in_valid held with stalled output: credits throttle acceptance
        for (int k = 0; k < 10; k++) begin
            cycle(1'b1, 1'b0, rblk());
            if (k == 3) chk("credit_exhausted", in_ready, 0);
        end
        idle(20, 1'b0);
        idle(40, 1'b1);
        chk("credit_no_overflow", overflow, 0);
`else
        // five blocks into a four-deep stalled FIFO
        for (int k = 0; k < 5; k++) cycle(1'b1, 1'b0, rblk());
        idle(L + 3, 1'b0);
        chk("drop_overflow", overflow, 1);
        idle(30, 1'b1);
        chk("overflow_sticky", overflow, 1);
`endif
        do_reset();

        // reset mid-stream with one resident and two in-flight blocks
        cycle(1'b1, 1'b0, rblk());
        idle(L + 1, 1'b0);
        chk("pre_reset_valid", out_valid, 1);
        cycle(1'b1, 1'b0, rblk());
        cycle(1'b1, 1'b0, rblk());
        idle(2, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_in_ready", in_ready, 1);
        chk("async_rst_data", out_data, 0);
        idle(2, 1'b1);
        rst_n = 1'b1;
        idle(L + 10, 1'b1);

        // randomised traffic
        for (int k = 0; k < 400; k++) begin
            cycle($urandom_range(1, 0) == 1, $urandom_range(9, 0) < 6, rblk());
        end
        idle(L + 4 * D + 20, 1'b1);
        chk("scoreboard_drained", exp_w.size(), 0);
        chk("nothing_in_flight", pend_due.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/aes_out_unpacker.md
AES_OUT_UNPACKER -- requirements
Module: aes_out_unpacker

Interface
REQ-001 SHALL have parameter LATENCY, default 12: clock edges from in_valid sampled to result capture from the pipelined AES core.
REQ-002 SHALL have parameter DEPTH, default 4: capacity of the result FIFO, in 128-bit blocks.
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
REQ-004 SHALL have these ports, as name / direction / width / meaning:
- clk  input  1  rising-edge clock, shared with the AES core.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  marks a block presented to the core's data_in this cycle.
- in_ready  output  1  block acceptance permitted; see REQ-020.
- aes_data  input  128  the core's data_out.
- out_data  output  32  ciphertext word.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts the word.
- out_last  output  1  final word of a block.
- overflow  output  1  sticky; a result was dropped.

Function
REQ-005 A block SHALL be accepted on a rising edge E0 where in_valid=1 and in_ready=1; in_valid while in_ready=0 SHALL be ignored.
REQ-006 SHALL track accepted blocks in a LATENCY-stage valid shift register.
REQ-007 aes_data SHALL be captured into the FIFO tail on edge E0+LATENCY for each accepted block.
REQ-008 Back-to-back accepted blocks, one per cycle, SHALL be captured on consecutive edges.
REQ-009 out_valid SHALL be 1 iff the FIFO is non-empty.
REQ-010 out_data SHALL be the head block's word[idx], a combinational view of the registered FIFO head.
- idx 0 = bits 127:96; idx 3 = bits 31:0.
REQ-011 idx SHALL be a 2-bit counter that advances on each edge with out_valid and out_ready both 1.
- When idx=3 it SHALL wrap to 0 and pop the head.
REQ-012 out_last SHALL equal out_valid and (idx==3).
REQ-013 out_data, out_last and idx SHALL hold while out_valid=1 and out_ready=0.
REQ-014 First word latency: out_valid SHALL rise on the cycle after edge E0+LATENCY when the FIFO was empty.
REQ-015 FIFO pointers SHALL wrap modulo DEPTH; the occupancy counter SHALL be clog2(DEPTH+1) bits wide.
REQ-016 Capture and pop on the same edge SHALL both occur, leaving occupancy unchanged, including when the FIFO is full.
REQ-017 Capture while full without a same-edge pop SHALL drop the block, leave the FIFO unchanged and set overflow=1.
REQ-018 overflow SHALL stay set until reset.

Reset
REQ-019 With rst_n=0, asynchronously and regardless of in-flight activity:
- Delay line, FIFO pointers, occupancy, idx, credit counter and overflow SHALL all be 0.
- out_valid and out_last SHALL be 0.
- out_data SHALL be 0.
- in_ready SHALL be 1.
- Blocks in flight are discarded.

Configuration
REQ-020 Macro AES_OUT_CREDIT_EN SHALL control flow control:
- Defined: a credit counter of (in-flight + FIFO-resident) blocks SHALL increment on acceptance and decrement on pop; a same-edge accept and pop SHALL leave it unchanged.
- Defined: in_ready SHALL be (credit < DEPTH), and overflow SHALL never set under legal stimulus.
- Undefined: in_ready SHALL be tied to 1, no credit counter SHALL exist, and REQ-017 governs.

Verification
REQ-021 SHALL cover: key 000102030405060708090a0b0c0d0e0f, in_valid pulse with plaintext 00112233445566778899aabbccddeeff, out_ready=1 -> 4 words 69c4e0d8, 6a7b0430, d8cdb780, 70b4c55a, the last with out_last=1, first word 13 cycles after the accept edge.
REQ-022 SHALL cover: 3 back-to-back blocks with out_ready=0 for 20 cycles, then 1 -> 12 words in block order, out_data stable while stalled, overflow=0.
REQ-023 SHALL cover, without AES_OUT_CREDIT_EN: 5 back-to-back blocks with out_ready=0 -> first 4 stored, fifth dropped, overflow=1 from edge E0+4+LATENCY.
REQ-024 SHALL cover, with AES_OUT_CREDIT_EN: in_valid held for 10 cycles with out_ready=0 -> in_ready falls after 4 accepts and rises the cycle after the first out_last handshake.
REQ-025 SHALL cover: FIFO full, with idx=3 handshake on the same edge as a capture -> occupancy stays 4 and no overflow.
REQ-026 SHALL cover: rst_n pulsed low mid-stream with 2 blocks in flight -> out_valid=0 immediately, no words emitted afterwards, and in_ready=1.
